ff256_horner_eval: RTL and testbench
====================================

# ff256_horner_eval

Streaming GF(2^8) polynomial evaluator. Accepts a frame of coefficient bytes, highest degree first, over a valid/ready handshake, and computes acc = c·acc ⊕ byte with Horner's rule. The per-beat multiply by the fixed point c is done by the existing constant multiplier. One result byte is emitted per frame, together with the frame length. The block sits directly upstream of consumers of single field elements, such as syndrome and check-symbol stages. It is the sequential wrapper around ff256_mult_by_const_multiplier.

## Interface
Field polynomial: x^8+x^4+x^3+x^2+1 (0x11D).

- CNST_COLS, default '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1D}: column images c·x^i for i = 0..7, where c is the evaluation point. The default is c = 0x02.
- LEN_W, default 8: width of the frame-length counter.

Ports:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  8  coefficient byte.
- in_valid  in  1  in_data is valid.
- in_last  in  1  beat is the final (constant-term) coefficient of the frame.
- in_ready  out  1  block accepts a beat this cycle.
- out_data  out  8  evaluated result.
- out_len  out  LEN_W  number of beats in the frame, saturating.
- out_ovf  out  1  frame length exceeded 2^LEN_W−1.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.

## Operation
- Two states.
  - ACCUM: collecting a frame. in_ready = 1.
  - HOLD: result presented. in_ready = 0.
- Accept is defined as in_valid & in_ready.
- On accept in ACCUM:
  - nxt = mult(acc) ⊕ in_data, where mult is the combinational multiply by c.
  - cnt increments, saturating at 2^LEN_W−1.
  - ovf is set sticky when an accept arrives with cnt already saturated.
- On accept with in_last = 0: acc ← nxt. Stay in ACCUM.
- On accept with in_last = 1:
  - out_data ← nxt, out_len ← cnt+1 (saturated), out_ovf ← ovf (or the newly set ovf).
  - out_valid ← 1.
  - acc, cnt and ovf clear to 0.
  - Go to HOLD.
- In HOLD, when out_valid & out_ready: out_valid ← 0, go to ACCUM.
- acc starts at 0, so the first beat contributes in_data unchanged. A single-beat frame yields out_data = in_data and out_len = 1.
- in_data and in_last are ignored when no accept occurs.
- Reset in any state, including mid-frame or in HOLD:
  - acc, cnt, ovf, out_data, out_len, out_ovf = 0.
  - out_valid = 0, state = ACCUM.
  - Any partial frame or pending result is discarded.

## Timing
- Throughput: one coefficient per cycle inside a frame.
- Latency: out_valid rises on the first edge after the in_last accept, i.e. 1 cycle.
- in_ready = (state == ACCUM). It is registered-state only, with no combinational path from out_ready or in_valid.
- Frame-to-frame gap:
  - Best case: the result is consumed the cycle it appears, then one cycle passes before in_ready returns.
  - Each frame therefore costs length+1 cycles minimum.
- out_data, out_len and out_ovf stay stable while out_valid = 1 and out_ready = 0.
- The multiply is combinational, so the critical path is 8-input XOR trees after the acc register.

## Structure
- Package ff256_pkg contains:
  - Field polynomial constant 9'h11D.
  - byte_t typedef.
  - cnst_cols_t, a logic [7:0] [0:7] array type.
  - Default column constant for c = 0x02.
- Sub-module: one ff256_mult_by_const_multiplier instance with cnst = CNST_COLS, p_in = acc and p_out = mult(acc).
- State is a two-value enum local to the module.

## Test plan
- Reset with out_ready = 1. Frame [01, 00] → out_data = 02, out_len = 1 less than the next case's 3, specifically out_len = 2, out_ovf = 0, out_valid 1 cycle after the last accept.
- Frame [01, 02, 03] → out_data = 03, out_len = 3. Frame [80, 00] → out_data = 1D, which exercises polynomial reduction.
- Backpressure:
  - Single-beat frame [A5] with out_ready = 0 for 5 cycles → out_data = A5 and out_len = 1 held stable, in_ready = 0 throughout.
  - Then out_ready = 1 → out_valid drops and in_ready returns the next cycle.
- LEN_W = 2, 4-beat frame [00, 00, 00, 07] → out_data = 07, out_len = 3, out_ovf = 1. The following 1-beat frame gives out_ovf = 0.
- Reset mid-frame:
  - Accept [FF, FF], assert rst 1 cycle.
  - Then send frame [11] → out_data = 11, out_len = 1. No residue from the aborted frame.
- Random frames of length 1–40 with random in_valid and out_ready gaps, checked against a software Horner model over 0x11D.

Source files
------------

// File: rtl/ff256_pkg.sv
// rtl/ff256_pkg.sv - GF(2^8) field types and constants shared by the Horner evaluator
package ff256_pkg;

  localparam logic [8:0] FIELD_POLY = 9'h11D;

  typedef logic [7:0] byte_t;

  // Element i is c*x^i reduced by FIELD_POLY, i.e. column i of the multiply-by-c matrix.
  typedef logic [7:0] cnst_cols_t [0:7];

  localparam cnst_cols_t CNST_COLS_C2 = '{8'h02, 8'h04, 8'h08, 8'h10,
                                         8'h20, 8'h40, 8'h80, 8'h1D};

endpackage

// File: rtl/ff256_mult_by_const_multiplier.sv
// rtl/ff256_mult_by_const_multiplier.sv - combinational multiply of a field element by a fixed constant
module ff256_mult_by_const_multiplier
  import ff256_pkg::*;
(
  input  cnst_cols_t cnst,
  input  byte_t      p_in,
  output byte_t      p_out
);

  // Each set input bit selects its precomputed column; the product is their XOR.
  always_comb begin
    p_out = '0;
    for (int i = 0; i < 8; i++) begin
      if (p_in[i]) p_out = p_out ^ cnst[i];
    end
  end

endmodule

// File: rtl/ff256_horner_eval.sv
// rtl/ff256_horner_eval.sv - streaming GF(2^8) Horner evaluator, one result per coefficient frame
module ff256_horner_eval
  import ff256_pkg::*;
#(
  parameter cnst_cols_t CNST_COLS = CNST_COLS_C2,
  parameter int         LEN_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic [LEN_W-1:0] out_len,
  output logic             out_ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state, state_nxt;
  byte_t            acc, acc_mult, nxt;
  logic [LEN_W-1:0] cnt, cnt_inc;
  logic             ovf, ovf_nxt, cnt_sat, accept;

  ff256_mult_by_const_multiplier u_mult (
    .cnst  (CNST_COLS),
    .p_in  (acc),
    .p_out (acc_mult)
  );

  assign accept  = in_valid & in_ready;
  assign nxt     = acc_mult ^ in_data;
  assign cnt_sat = &cnt;
  assign cnt_inc = cnt_sat ? cnt : cnt + 1'b1;
  assign ovf_nxt = ovf | cnt_sat;

  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = (state == ACCUM);
    case (state)
      ACCUM:   if (accept && in_last)      state_nxt = HOLD;
      HOLD:    if (out_valid && out_ready) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  // Accumulator state clears on the last beat so the next frame starts from zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      ovf       <= 1'b0;
      out_data  <= '0;
      out_len   <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else if (accept) begin
      if (in_last) begin
        out_data  <= nxt;
        out_len   <= cnt_inc;
        out_ovf   <= ovf_nxt;
        out_valid <= 1'b1;
        acc       <= '0;
        cnt       <= '0;
        ovf       <= 1'b0;
      end else begin
        acc <= nxt;
        cnt <= cnt_inc;
        ovf <= ovf_nxt;
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ff256_horner_eval.sv
// tb/tb_ff256_horner_eval.sv - self-checking bench for ff256_horner_eval
module tb_ff256_horner_eval;
  import ff256_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid, in_last, in_ready;
  logic [7:0] out_data;
  logic [7:0] out_len;
  logic       out_ovf, out_valid, out_ready;

  logic [7:0] in2_data;
  logic       in2_valid, in2_last, in2_ready;
  logic [7:0] out2_data;
  logic [1:0] out2_len;
  logic       out2_ovf, out2_valid, out2_ready;

  int n_tests = 0;
  int n_fail  = 0;
  bit rnd_phase = 1'b0;
  bit mon_en    = 1'b0;
  byte_t got_d[$];
  int    got_l[$];
  byte_t exp_d[$];
  int    exp_l[$];

  always #5 clk = ~clk;

  ff256_horner_eval #(.CNST_COLS(CNST_COLS_C2), .LEN_W(8)) u_dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .out_data(out_data), .out_len(out_len), .out_ovf(out_ovf),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  ff256_horner_eval #(.CNST_COLS(CNST_COLS_C2), .LEN_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_data(in2_data), .in_valid(in2_valid), .in_last(in2_last),
    .in_ready(in2_ready), .out_data(out2_data), .out_len(out2_len), .out_ovf(out2_ovf),
    .out_valid(out2_valid), .out_ready(out2_ready)
  );

  // Reference: schoolbook shift-and-add multiply over 0x11D, then Horner fold with c = 2.
  function automatic byte_t gf_mul(input byte_t a, input byte_t b);
    int p = 0;
    int x = int'(a);
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x << 1;
      if ((x & 'h100) != 0) x = x ^ 'h11D;
    end
    return byte_t'(p);
  endfunction

  function automatic byte_t horner(input byte_t q[$]);
    byte_t a = 8'h00;
    foreach (q[i]) a = gf_mul(a, 8'h02) ^ q[i];
    return a;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_phase) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) begin
      got_d.push_back(out_data);
      got_l.push_back(int'(out_len));
    end
  end

  task automatic drive_beat(input byte_t d, input logic last);
    bit done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    for (int t = 0; t < 300 && !done; t++) begin
      done = in_ready;
      tick();
    end
    if (!done) check("accept_timeout", 0, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_frame(input byte_t q[$], input bit gaps);
    foreach (q[i]) begin
      if (gaps) begin
        int g = $urandom_range(0, 2);
        for (int k = 0; k < g; k++) begin
          in_data = byte_t'($urandom);
          in_last = 1'($urandom);
          tick();
        end
        in_last = 1'b0;
      end
      drive_beat(q[i], (i == q.size() - 1));
    end
  endtask

  typedef struct {
    int    len;
    byte_t d [4];
    byte_t exp_d;
    int    exp_l;
  } vec_t;

  vec_t  vt [4];
  byte_t q[$];

  initial begin
    vt[0] = '{2, '{8'h01, 8'h00, 8'h00, 8'h00}, 8'h02, 2};
    vt[1] = '{3, '{8'h01, 8'h02, 8'h03, 8'h00}, 8'h03, 3};
    vt[2] = '{2, '{8'h80, 8'h00, 8'h00, 8'h00}, 8'h1D, 2};
    vt[3] = '{1, '{8'hC3, 8'h00, 8'h00, 8'h00}, 8'hC3, 1};

    rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    in2_data = 8'h00; in2_valid = 1'b0; in2_last = 1'b0; out2_ready = 1'b1;
    tick(); tick();
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_len", int'(out_len), 0);
    check("rst_out_ovf", int'(out_ovf), 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) begin
      q = {};
      for (int j = 0; j < vt[i].len; j++) q.push_back(vt[i].d[j]);
      send_frame(q, 1'b0);
      check($sformatf("vec%0d_latency", i), int'(out_valid), 1);
      check($sformatf("vec%0d_data", i), int'(out_data), int'(vt[i].exp_d));
      check($sformatf("vec%0d_len", i), int'(out_len), vt[i].exp_l);
      check($sformatf("vec%0d_ovf", i), int'(out_ovf), 0);
      check($sformatf("vec%0d_gap_ready", i), int'(in_ready), 0);
      tick();
      check($sformatf("vec%0d_consumed", i), int'(out_valid), 0);
      check($sformatf("vec%0d_ready_back", i), int'(in_ready), 1);
    end

    out_ready = 1'b0;
    q = {8'hA5};
    send_frame(q, 1'b0);
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", int'(out_valid), 1);
      check("bp_data", int'(out_data), 'hA5);
      check("bp_len", int'(out_len), 1);
      check("bp_in_ready", int'(in_ready), 0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_valid", int'(out_valid), 0);
    check("bp_release_ready", int'(in_ready), 1);

    in2_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("len2_ready", int'(in2_ready), 1);
      in2_data = (k == 3) ? 8'h07 : 8'h00;
      in2_last = (k == 3);
      tick();
    end
    in2_valid = 1'b0; in2_last = 1'b0;
    check("len2_valid", int'(out2_valid), 1);
    check("len2_data", int'(out2_data), 'h07);
    check("len2_len", int'(out2_len), 3);
    check("len2_ovf", int'(out2_ovf), 1);
    tick();
    check("len2_ready_back", int'(in2_ready), 1);
    in2_valid = 1'b1; in2_data = 8'h09; in2_last = 1'b1;
    tick();
    in2_valid = 1'b0; in2_last = 1'b0;
    check("len2_next_valid", int'(out2_valid), 1);
    check("len2_next_data", int'(out2_data), 'h09);
    check("len2_next_len", int'(out2_len), 1);
    check("len2_next_ovf", int'(out2_ovf), 0);
    tick();

    drive_beat(8'hFF, 1'b0);
    drive_beat(8'hFF, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_valid", int'(out_valid), 0);
    check("midrst_ready", int'(in_ready), 1);
    q = {8'h11};
    send_frame(q, 1'b0);
    check("midrst_data", int'(out_data), 'h11);
    check("midrst_len", int'(out_len), 1);
    check("midrst_ovf", int'(out_ovf), 0);
    tick();

    mon_en = 1'b1;
    rnd_phase = 1'b1;
    for (int f = 0; f < 30; f++) begin
      int n = $urandom_range(1, 40);
      q = {};
      for (int j = 0; j < n; j++) q.push_back(byte_t'($urandom));
      exp_d.push_back(horner(q));
      exp_l.push_back(n);
      send_frame(q, 1'b1);
    end
    for (int t = 0; t < 200 && got_d.size() < exp_d.size(); t++) tick();
    rnd_phase = 1'b0;
    mon_en = 1'b0;
    check("rnd_count", got_d.size(), exp_d.size());
    for (int i = 0; i < exp_d.size() && i < got_d.size(); i++) begin
      check($sformatf("rnd%0d_data", i), int'(got_d[i]), int'(exp_d[i]));
      check($sformatf("rnd%0d_len", i), got_l[i], exp_l[i]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
